sd_cmd_sequencer: RTL and testbench

SPI-mode SD command sequencer that drives the command_store lookup. It steps the byte index through a 6-byte command frame and serialises each byte MSB-first onto MOSI. It then waits for the card's R1 response start bit and captures the 8-bit R1 byte. It sits between the SD top-level FSM, which issues start, cmd_select and address, and the SPI pin logic. Bit pacing comes from an external bit_tick strobe produced by the SPI clock divider.

---
 rtl/sd_cmd_sequencer.sv | 157 +++++++++++++++
 tb/tb_sd_cmd_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_sequencer.sv
// SPI-mode SD command sequencer: walks command_store through a CMD_BYTES frame,
// serialises it MSB-first on MOSI, then waits for and captures the R1 response.
module sd_cmd_sequencer #(
  parameter int unsigned CMD_BYTES = 6,
  parameter int unsigned NCR_BITS  = 64
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  input  logic [5:0]  cmd_select_in,
  input  logic [31:0] address_in,
  input  logic        bit_tick,
  input  logic        miso,
  input  logic [7:0]  cmd,
  output logic [5:0]  cmd_select,
  output logic [31:0] address,
  output logic [7:0]  counter,
  output logic        mosi,
  output logic        cs_n,
  output logic        sclk_en,
  output logic        busy,
  output logic        done,
  output logic [7:0]  resp,
  output logic        timeout
);

  localparam int unsigned WW = $clog2(NCR_BITS) + 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    WAIT_RESP,
    READ_RESP,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [5:0]      cmd_select_q, cmd_select_d;
  logic [31:0]     address_q, address_d;
  logic [7:0]      counter_q, counter_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [7:0]      resp_q, resp_d;
  logic            timeout_q, timeout_d;

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state_q      <= IDLE;
      cmd_select_q <= '0;
      address_q    <= '0;
      counter_q    <= '0;
      shreg_q      <= '1;
      bit_cnt_q    <= '0;
      wait_cnt_q   <= '0;
      resp_q       <= '1;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_select_q <= cmd_select_d;
      address_q    <= address_d;
      counter_q    <= counter_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      resp_q       <= resp_d;
      timeout_q    <= timeout_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cmd_select_d = cmd_select_q;
    address_d    = address_q;
    counter_d    = counter_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    resp_d       = resp_q;
    timeout_d    = timeout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          cmd_select_d = cmd_select_in;
          address_d    = address_in;
          counter_d    = '0;
          resp_d       = '1;
          timeout_d    = 1'b0;
          state_d      = LOAD;
        end
      end
      LOAD: begin
        shreg_d   = cmd;
        bit_cnt_d = '0;
        state_d   = SHIFT;
      end
      SHIFT: begin
        if (bit_tick) begin
          shreg_d   = {shreg_q[6:0], 1'b1};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (counter_q == 8'(CMD_BYTES - 1)) begin
              wait_cnt_d = '0;
              state_d    = WAIT_RESP;
            end else begin
              counter_d = counter_q + 8'd1;
              state_d   = LOAD;
            end
          end
        end
      end
      WAIT_RESP: begin
        // The start bit is also the MSB of R1, so it enters the shift register.
        if (bit_tick) begin
          if (!miso) begin
            shreg_d   = {shreg_q[6:0], 1'b0};
            bit_cnt_d = 3'd1;
            state_d   = READ_RESP;
          end else if (wait_cnt_q == WW'(NCR_BITS - 1)) begin
            timeout_d = 1'b1;
            state_d   = DONE;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end
      end
      READ_RESP: begin
        if (bit_tick) begin
          shreg_d   = {shreg_q[6:0], miso};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            resp_d  = {shreg_q[6:0], miso};
            state_d = DONE;
          end
        end
      end
      DONE: begin
        counter_d = '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_select = cmd_select_q;
  assign address    = address_q;
  assign counter    = counter_q;
  assign resp       = resp_q;
  assign timeout    = timeout_q;
  assign mosi       = (state_q == SHIFT) ? shreg_q[7] : 1'b1;
  assign busy       = (state_q != IDLE) && (state_q != DONE);
  assign cs_n       = !busy;
  assign sclk_en    = busy;
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Directed bench for sd_cmd_sequencer with a command_store model, an SPI bit
// pacer and a card model that answers with a programmable R1 after N idle bits.
module tb_sd_cmd_sequencer;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        start;
  logic [5:0]  cmd_select_in;
  logic [31:0] address_in;
  logic        bit_tick = 1'b0;
  logic        miso = 1'b1;
  logic [7:0]  cmd;
  logic [5:0]  cmd_select;
  logic [31:0] address;
  logic [7:0]  counter;
  logic        mosi, cs_n, sclk_en, busy, done, timeout;
  logic [7:0]  resp;

  int n_cmp = 0;
  int n_bad = 0;

  sd_cmd_sequencer #(.CMD_BYTES(6), .NCR_BITS(64)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .cmd_select_in(cmd_select_in),
    .address_in(address_in), .bit_tick(bit_tick), .miso(miso), .cmd(cmd),
    .cmd_select(cmd_select), .address(address), .counter(counter), .mosi(mosi),
    .cs_n(cs_n), .sclk_en(sclk_en), .busy(busy), .done(done), .resp(resp),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] store_byte(input logic [5:0] sel, input logic [7:0] idx,
                                            input logic [31:0] a);
    case (idx)
      8'd0:    store_byte = 8'h40 | {2'b00, sel};
      8'd1:    store_byte = a[31:24];
      8'd2:    store_byte = a[23:16];
      8'd3:    store_byte = a[15:8];
      8'd4:    store_byte = a[7:0];
      8'd5:    store_byte = (sel == 6'd0) ? 8'h95 : 8'hFF;
      default: store_byte = 8'hFF;
    endcase
  endfunction

  function automatic logic [47:0] frame48(input logic [5:0] sel, input logic [31:0] a);
    logic [47:0] f = '0;
    for (int i = 0; i < 6; i++) f = {f[39:0], store_byte(sel, 8'(i), a)};
    return f;
  endfunction

  always_comb cmd = store_byte(cmd_select, counter, address);

  int          card_delay = 1000;
  logic [7:0]  card_byte = 8'hFF;

  function automatic logic card_bit(input int k);
    int r = k - 48 - card_delay;
    if (k < 48 + card_delay) return 1'b1;
    if (r < 8) return card_byte[7-r];
    return 1'b1;
  endfunction

  // Bit pacer: one tick every 4 clocks while sclk_en; capture and bookkeeping per tick.
  int          tick_idx = 0;
  int          div = 0;
  int          bad_ctr = 0;
  logic [47:0] mosi_cap = '0;

  always @(negedge clk) begin
    if (busy !== 1'b1) begin
      tick_idx = 0; div = 0; bad_ctr = 0; mosi_cap = '0; bit_tick = 1'b0; miso = 1'b1;
    end else if (sclk_en && div == 3) begin
      div = 0;
      bit_tick = 1'b1;
      miso = card_bit(tick_idx);
      if (tick_idx < 48) begin
        mosi_cap = {mosi_cap[46:0], mosi};
        if (counter !== 8'(tick_idx / 8)) bad_ctr++;
      end
      tick_idx++;
    end else begin
      bit_tick = 1'b0;
      if (sclk_en) div++;
    end
  end

  task automatic run_txn(input logic [5:0] sel, input logic [31:0] a, input int delay,
                         input logic [7:0] rb, input logic [7:0] exp_resp, input logic exp_to,
                         input int exp_ticks, input bit busy_start, input bit done_start);
    int  ncyc = 0;
    int  bad_cs = 0;
    bit  got_done = 0;
    card_delay = delay;
    card_byte  = rb;
    @(negedge clk);
    cmd_select_in = sel; address_in = a; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_after_start", busy, 1);
    check_eq("cs_low_after_start", cs_n, 0);
    while (!got_done && ncyc < 3000) begin
      @(posedge clk); #1;
      ncyc++;
      if (done) got_done = 1;
      else begin
        if (cs_n !== 1'b0) bad_cs++;
        if (busy_start && ncyc == 30) begin
          start = 1'b1; cmd_select_in = 6'd17; address_in = 32'hFFFF_FFFF;
        end else start = 1'b0;
      end
    end
    check_eq("done_seen", got_done, 1);
    check_eq("mosi_frame", mosi_cap, frame48(sel, a));
    check_eq("counter_seq", bad_ctr, 0);
    check_eq("cs_low_during", bad_cs, 0);
    check_eq("tick_total", tick_idx, exp_ticks);
    check_eq("resp", resp, exp_resp);
    check_eq("timeout", timeout, exp_to);
    check_eq("done_cs_n", cs_n, 1);
    check_eq("done_busy", busy, 0);
    check_eq("done_sclk_en", sclk_en, 0);
    check_eq("done_mosi", mosi, 1);
    check_eq("latched_sel", cmd_select, sel);
    if (done_start) begin
      start = 1'b1; cmd_select_in = sel;
    end
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("done_one_cycle", done, 0);
    check_eq("idle_after_done", busy, 0);
    check_eq("counter_cleared", counter, 0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("resp_held", resp, exp_resp);
    check_eq("timeout_held", timeout, exp_to);
    check_eq("still_idle", busy, 0);
  endtask

  initial begin
    n_rst = 1'b1; start = 1'b0; cmd_select_in = '0; address_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_cs_n", cs_n, 1);
    check_eq("rst_mosi", mosi, 1);
    check_eq("rst_resp", resp, 8'hFF);
    check_eq("rst_misc", {busy, done, sclk_en, timeout, counter, cmd_select}, '0);
    @(negedge clk); n_rst = 1'b0;

    // CMD0, 16 idle bits then R1=01; start during DONE must be ignored
    run_txn(6'd0, 32'd0, 16, 8'h01, 8'h01, 1'b0, 72, 1'b0, 1'b1);
    // CMD17 with a read address, R1=00 after 3 idle bits
    run_txn(6'd17, 32'd9387173, 3, 8'h00, 8'h00, 1'b0, 59, 1'b0, 1'b0);
    // no start bit ever: timeout after 64 wait ticks
    run_txn(6'd17, 32'h1234_5678, 1000, 8'hFF, 8'hFF, 1'b1, 112, 1'b0, 1'b0);
    // start with cmd 17 pulsed during the CMD0 frame
    run_txn(6'd0, 32'd0, 5, 8'h01, 8'h01, 1'b0, 61, 1'b1, 1'b0);
    // start bit on the very first wait tick
    run_txn(6'd0, 32'd0, 0, 8'h05, 8'h05, 1'b0, 56, 1'b0, 1'b0);

    // reset during byte 2
    card_delay = 1000;
    @(negedge clk);
    cmd_select_in = 6'd17; address_in = 32'hA5A5_0F0F; start = 1'b1;
    @(negedge clk); start = 1'b0;
    begin
      int w = 0;
      while (counter !== 8'd2 && w < 500) begin @(posedge clk); #1; w++; end
      check_eq("reached_byte2", counter, 2);
    end
    repeat (5) @(posedge clk);
    #1;
    n_rst = 1'b1;
    #1;
    check_eq("midrst_cs_n", cs_n, 1);
    check_eq("midrst_mosi", mosi, 1);
    check_eq("midrst_resp", resp, 8'hFF);
    check_eq("midrst_misc", {busy, done, sclk_en, timeout, counter, cmd_select}, '0);
    @(negedge clk); n_rst = 1'b0;
    run_txn(6'd17, 32'h0BAD_F00D, 2, 8'h3C, 8'h3C, 1'b0, 58, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
